// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port sequencer for the 4096x4 asynchronous RAM.
// Each access runs SETUP/ACCESS/HOLD so address and data are stable around the write strobe.
module ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              grant_id,
  output logic [ADDR_W-1:0] address_RAM,
  output logic              csRAM,
  output logic              weRAM,
  inout  wire  [DATA_W-1:0] saved_data
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
  state_t state, next;
  logic win, last_grant, lat_we, oe;
  logic [DATA_W-1:0] wdata_q;

  assign win = (req0 && req1) ? !last_grant : req1;
  assign saved_data = oe ? wdata_q : {DATA_W{1'bz}};

  always_comb begin
    next = state;
    case (state)
      IDLE:    next = (req0 || req1) ? SETUP : IDLE;
      SETUP:   next = ACCESS;
      ACCESS:  next = HOLD;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;

  // outputs are registered from the next state so the RAM pins never see req* combinationally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_RAM <= '0;
      wdata_q     <= '0;
      rdata       <= '0;
      csRAM       <= 1'b0;
      weRAM       <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= 1'b0;
      last_grant  <= 1'b1;
      lat_we      <= 1'b0;
      oe          <= 1'b0;
    end else begin
      busy  <= next != IDLE;
      csRAM <= next == ACCESS;
      weRAM <= next == ACCESS && lat_we;
      ack0  <= next == HOLD && !grant_id;
      ack1  <= next == HOLD && grant_id;
      if (state == IDLE && (req0 || req1)) begin
        grant_id    <= win;
        last_grant  <= win;
        lat_we      <= win ? we1 : we0;
        oe          <= win ? we1 : we0;
        address_RAM <= win ? addr1 : addr0;
        wdata_q     <= win ? wdata1 : wdata0;
      end else if (next == IDLE) oe <= 1'b0;
      if (state == ACCESS && !lat_we) rdata <= saved_data;
    end
  end
endmodule
